// File: rtl/cfi_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// cfi_buffer_ctrl_if
// Bus bundle between the commit ports, the control-flow buffer sequencer and
// the CAM-style address buffer.
//   ev_valid  [1:0]        per-port event valid (port 0 is older than port 1)
//   ev_is_ret [1:0]        1 = return (check), 0 = call (record)
//   ev_addr   [1:0][31:0]  call: return address to record; return: target
//   ev_ready               sequencer can take two events this cycle
//   buf_write              one-cycle write strobe into the buffer
//   buf_data  [31:0]       address written into the buffer
//   buf_find  [31:0]       lookup key presented to the buffer
//   buf_hit                buffer lookup result for buf_find, same cycle
// Modports: master = event producer plus buffer side, slave = sequencer.
// -----------------------------------------------------------------------------
interface cfi_buffer_ctrl_if;
  logic [1:0]       ev_valid;
  logic [1:0]       ev_is_ret;
  logic [1:0][31:0] ev_addr;
  logic             ev_ready;
  logic             buf_write;
  logic [31:0]      buf_data;
  logic [31:0]      buf_find;
  logic             buf_hit;

  modport master (
    output ev_valid, ev_is_ret, ev_addr, buf_hit,
    input  ev_ready, buf_write, buf_data, buf_find
  );

  modport slave (
    input  ev_valid, ev_is_ret, ev_addr, buf_hit,
    output ev_ready, buf_write, buf_data, buf_find
  );
endinterface

// File: rtl/cfi_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// cfi_buffer_ctrl
// Sequencer for the control-flow-integrity address buffer. Call/return events
// from two commit ports are queued in program order and drained one per cycle:
// a call writes its return address into the buffer, a return looks its target
// up. A lookup miss latches a sticky violation and halts draining until
// clear_i.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        0: incoming events are ignored, the queue keeps draining
//   clear_i         flush queue, clear sticky flags, back to IDLE
//   bus (slave)     event handshake and buffer write/lookup signals
//   violation_o     sticky: a return target missed the buffer
//   viol_addr_o     target address of the first missing return
//   overflow_o      sticky: event presented while the queue was not ready
//   busy_o          queue non-empty or FSM not IDLE
// -----------------------------------------------------------------------------
module cfi_buffer_ctrl #(
  parameter int QDEPTH_LOG2 = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  cfi_buffer_ctrl_if.slave bus,
  output logic             violation_o,
  output logic [31:0]      viol_addr_o,
  output logic             overflow_o,
  output logic             busy_o
);
  localparam int DEPTH = 1 << QDEPTH_LOG2;
  // Two free slots are needed so both ports can always be accepted together.
  localparam logic [QDEPTH_LOG2:0] READY_MAX = (QDEPTH_LOG2 + 1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [QDEPTH_LOG2-1:0] r_wr_ptr;
  logic [QDEPTH_LOG2-1:0] r_rd_ptr;
  logic [QDEPTH_LOG2-1:0] w_wr_idx1;
  logic [QDEPTH_LOG2:0]   r_count;
  logic [QDEPTH_LOG2:0]   w_count_next;
  logic [QDEPTH_LOG2:0]   w_push_ext;
  logic [31:0]            r_q_addr [DEPTH];
  logic                   r_q_ret  [DEPTH];
  logic                   r_violation;
  logic [31:0]            r_viol_addr;
  logic                   r_overflow;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_write;
  logic                   w_head_ret;
  logic [31:0]            w_head_addr;
  logic                   w_miss;
  logic                   w_ovf_event;
  logic [1:0]             w_push_cnt;

  assign w_ready     = (r_count <= READY_MAX) && (r_state != ST_HALT);
  assign w_accept    = enable_i && w_ready && !clear_i;
  assign w_push_cnt  = w_accept ? ({1'b0, bus.ev_valid[0]} + {1'b0, bus.ev_valid[1]}) : 2'd0;
  assign w_push_ext  = {{(QDEPTH_LOG2 - 1){1'b0}}, w_push_cnt};
  // A lone port-1 event takes the slot port 0 would have used.
  assign w_wr_idx1   = r_wr_ptr + {{(QDEPTH_LOG2 - 1){1'b0}}, bus.ev_valid[0]};

  // DRAIN always holds at least one entry, so the head is valid there.
  assign w_pop       = (r_state == ST_DRAIN) && !clear_i;
  assign w_head_ret  = r_q_ret[r_rd_ptr];
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_write     = w_pop && !w_head_ret;
  assign w_miss      = w_pop && w_head_ret && !bus.buf_hit;
  assign w_ovf_event = enable_i && !w_ready && (|bus.ev_valid) && (r_state != ST_HALT) && !clear_i;

  assign w_count_next = r_count + w_push_ext - {{QDEPTH_LOG2{1'b0}}, w_pop};

  assign bus.ev_ready  = w_ready;
  assign bus.buf_write = w_write;
  assign bus.buf_data  = w_write ? w_head_addr : 32'h0000_0000;
  assign bus.buf_find  = (w_pop && w_head_ret) ? w_head_addr : 32'h0000_0000;

  assign violation_o = r_violation;
  assign viol_addr_o = r_viol_addr;
  assign overflow_o  = r_overflow;
  assign busy_o      = (r_count != '0) || (r_state != ST_IDLE);

  // Next-state logic; leaving IDLE on enqueue gives a buffer action one cycle later.
  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_count_next != '0) begin
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_miss) begin
            w_state_next = ST_HALT;
          end else if (w_count_next == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DRAIN;
          end
        end
        ST_HALT:  w_state_next = ST_HALT;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // State, occupancy, pointers and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_violation <= 1'b0;
      r_viol_addr <= 32'h0000_0000;
      r_overflow  <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_violation <= 1'b0;
      r_viol_addr <= 32'h0000_0000;
      r_overflow  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_wr_ptr <= r_wr_ptr + w_push_ext[QDEPTH_LOG2-1:0];
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(QDEPTH_LOG2 - 1){1'b0}}, 1'b1};
      end
      if (w_miss && !r_violation) begin
        r_violation <= 1'b1;
        r_viol_addr <= w_head_addr;
      end
      if (w_ovf_event) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Queue storage; port 0 lands before port 1 to keep program order.
  always_ff @(posedge clk_i) begin
    if (w_accept && bus.ev_valid[0]) begin
      r_q_addr[r_wr_ptr] <= bus.ev_addr[0];
      r_q_ret[r_wr_ptr]  <= bus.ev_is_ret[0];
    end
    if (w_accept && bus.ev_valid[1]) begin
      r_q_addr[w_wr_idx1] <= bus.ev_addr[1];
      r_q_ret[w_wr_idx1]  <= bus.ev_is_ret[1];
    end
  end
endmodule
